// File: rtl/memory_game_pkg.sv
// +----------------------------------------------------------------------------+
// | memory_game_pkg : shared types and constants for the switch-memory game     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package memory_game_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        GEN   = 4'd1,
        SHOW  = 4'd2,
        GAP   = 4'd3,
        INPUT = 4'd4,
        CHECK = 4'd5,
        PASS  = 4'd6,
        WIN   = 4'd7,
        FAIL  = 4'd8
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [3:0] diff_units(input logic [1:0] d);
        return 4'd8 - {2'b00, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_lfsr.sv
// +----------------------------------------------------------------------------+
// | pattern_lfsr : 16-bit Fibonacci LFSR that advances only when step is high   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pattern_lfsr
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (step) begin
            value <= {^(value & LFSR_TAPS), value[15:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/memory_level_ctrl.sv
// +----------------------------------------------------------------------------+
// | memory_level_ctrl : generates, shows and checks switch patterns per level   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module memory_level_ctrl
    import memory_game_pkg::*;
#(
    parameter int          SW_W          = 10,
    parameter int          MAX_LEVEL     = 10,
    parameter int          SEQ_MAX       = 16,
    parameter int unsigned SHOW_UNIT     = 5_000_000,
    parameter int unsigned GAP_CYCLES    = 2_500_000,
    parameter int unsigned INPUT_TIMEOUT = 0,
    parameter logic [15:0] SEED          = DEFAULT_SEED
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             confirm,
    input  logic [SW_W-1:0]                  sw,
    input  logic [1:0]                       difficulty,
    output logic [SW_W-1:0]                  led,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
    output logic [$clog2(SEQ_MAX+1)-1:0]     good,
    output logic                             busy,
    output logic                             input_en,
    output logic                             win,
    output logic                             lose
);

    localparam int LW = $clog2(MAX_LEVEL + 1);
    localparam int CW = $clog2(SEQ_MAX + 1);
    localparam int AW = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    state_t          state, next_state;
    logic [SW_W-1:0] pbuf [0:(1<<AW)-1];
    logic [CW-1:0]   idx, len, show_sel;
    logic [31:0]     timer, show_cycles, level_plus1;
    logic [1:0]      diff_q;
    logic [SW_W-1:0] sw_q, show_pat, led_d;
    logic [15:0]     lfsr_val;
    logic            lfsr_unused;
    logic            gen_last, show_done, gap_done, seq_last, entry_match, timed_out;
    logic            busy_d, input_en_d, win_d, lose_d;

    pattern_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (state == GEN),
        .value (lfsr_val)
    );

    assign lfsr_unused = ^lfsr_val;
    assign level_plus1 = 32'(level) + 32'd1;
    assign len         = (level_plus1 < SEQ_MAX) ? CW'(level_plus1) : CW'(SEQ_MAX);
    assign show_cycles = SHOW_UNIT * 32'(diff_units(diff_q));
    assign gen_last    = (idx == len - CW'(1));
    assign show_done   = (timer + 32'd1 >= show_cycles);
    assign gap_done    = (timer + 32'd1 >= GAP_CYCLES);
    assign seq_last    = (idx + CW'(1) == len);
    assign entry_match = (sw_q == pbuf[idx[AW-1:0]]);
    assign timed_out   = (INPUT_TIMEOUT != 0) && (timer + 32'd1 >= INPUT_TIMEOUT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, WIN, FAIL: if (start)     next_state = GEN;
            GEN:             if (gen_last)  next_state = SHOW;
            SHOW:            if (show_done) next_state = GAP;
            GAP:             if (gap_done)  next_state = seq_last ? INPUT : SHOW;
            INPUT: begin
                if (confirm)        next_state = CHECK;
                else if (timed_out) next_state = FAIL;
            end
            CHECK:   next_state = !entry_match ? FAIL : (seq_last ? PASS : INPUT);
            PASS:    next_state = (level == LW'(MAX_LEVEL)) ? WIN : GEN;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state itself
    always_comb begin
        show_sel = '0;
        if (state == SHOW)     show_sel = idx;
        else if (state == GAP) show_sel = idx + CW'(1);
        show_pat = pbuf[show_sel[AW-1:0]];
        if (state == GEN && idx == '0) show_pat = lfsr_val[SW_W-1:0];
        led_d      = (next_state == SHOW) ? show_pat : '0;
        busy_d     = next_state inside {GEN, SHOW, GAP, CHECK};
        input_en_d = (next_state == INPUT);
        win_d      = (next_state == WIN);
        lose_d     = (next_state == FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led      <= '0;
            busy     <= 1'b0;
            input_en <= 1'b0;
            win      <= 1'b0;
            lose     <= 1'b0;
        end else begin
            led      <= led_d;
            busy     <= busy_d;
            input_en <= input_en_d;
            win      <= win_d;
            lose     <= lose_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state == GEN) pbuf[idx[AW-1:0]] <= lfsr_val[SW_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level  <= '0;
            good   <= '0;
            idx    <= '0;
            timer  <= '0;
            diff_q <= '0;
            sw_q   <= '0;
        end else begin
            case (state)
                IDLE, WIN, FAIL: if (start) begin
                    level  <= LW'(1);
                    good   <= '0;
                    idx    <= '0;
                    timer  <= '0;
                    diff_q <= difficulty;
                end
                GEN: begin
                    timer <= '0;
                    idx   <= gen_last ? '0 : idx + CW'(1);
                end
                SHOW: timer <= show_done ? '0 : timer + 32'd1;
                GAP: begin
                    if (gap_done) begin
                        timer <= '0;
                        if (seq_last) begin
                            idx  <= '0;
                            good <= '0;
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                INPUT: begin
                    if (confirm) begin
                        sw_q  <= sw;
                        timer <= '0;
                    end else if (INPUT_TIMEOUT != 0) begin
                        timer <= timer + 32'd1;
                    end
                end
                CHECK: if (entry_match) begin
                    good <= good + CW'(1);
                    idx  <= idx + CW'(1);
                end
                PASS: if (level != LW'(MAX_LEVEL)) begin
                    level  <= level + LW'(1);
                    good   <= '0;
                    idx    <= '0;
                    diff_q <= difficulty;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_level_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_memory_level_ctrl : self-checking bench for memory_level_ctrl            |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_memory_level_ctrl;

    localparam int          SW_W          = 10;
    localparam int          MAX_LEVEL     = 2;
    localparam int          SEQ_MAX       = 16;
    localparam int unsigned SHOW_UNIT     = 4;
    localparam int unsigned GAP_CYCLES    = 2;
    localparam int unsigned INPUT_TIMEOUT = 10;
    localparam logic [15:0] SEED          = 16'hACE1;
    localparam int          LW            = $clog2(MAX_LEVEL + 1);
    localparam int          GW            = $clog2(SEQ_MAX + 1);

    localparam int A_TIMEOUT = 0;
    localparam int A_WRONG2  = 1;
    localparam int A_WIN     = 2;
    localparam int A_LATE    = 3;

    typedef struct {
        logic [1:0] diff;
        logic [1:0] newdiff;
        int         act;
        int         show1;
        int         show2;
        int         exp_level;
        int         exp_good;
        logic       exp_win;
        logic       exp_lose;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset, start, confirm;
    logic [SW_W-1:0] sw;
    logic [1:0]      difficulty;
    logic [SW_W-1:0] led;
    logic [LW-1:0]   level;
    logic [GW-1:0]   good;
    logic            busy, input_en, win, lose;

    int              errors = 0;
    int              checks = 0;
    logic [15:0]     mlfsr;
    logic [SW_W-1:0] pat_q[$];
    int              good_q[$];
    logic [SW_W-1:0] cur [0:15];
    vec_t            vecs [4];

    memory_level_ctrl #(
        .SW_W(SW_W), .MAX_LEVEL(MAX_LEVEL), .SEQ_MAX(SEQ_MAX), .SHOW_UNIT(SHOW_UNIT),
        .GAP_CYCLES(GAP_CYCLES), .INPUT_TIMEOUT(INPUT_TIMEOUT), .SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .confirm(confirm), .sw(sw),
        .difficulty(difficulty), .led(led), .level(level), .good(good), .busy(busy),
        .input_en(input_en), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR: bit = l0^l2^l3^l5 shifted in at the top
    task automatic model_gen(input int len);
        for (int i = 0; i < len; i++) begin
            cur[i] = mlfsr[SW_W-1:0];
            pat_q.push_back(mlfsr[SW_W-1:0]);
            mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        end
    endtask

    // Called at the first GEN negedge; returns at the first INPUT negedge
    task automatic run_show(input int len, input int dur, input string tag);
        logic [SW_W-1:0] exp;
        int ok;
        check({tag, " busy_gen"}, busy, 1);
        model_gen(len);
        repeat (len) @(negedge clk);
        for (int p = 0; p < len; p++) begin
            exp = pat_q.pop_front();
            ok  = 0;
            for (int c = 0; c < dur + int'(GAP_CYCLES); c++) begin
                if (c < dur ? (led === exp) : (led === '0)) ok++;
                @(negedge clk);
            end
            check($sformatf("%s show_p%0d", tag, p), ok, dur + int'(GAP_CYCLES));
        end
        check({tag, " input_en"}, input_en, 1);
        check({tag, " good0"}, good, 0);
    endtask

    task automatic start_game(input logic [1:0] d, input logic [1:0] nd);
        difficulty = d;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        difficulty = nd;
        check("start level", level, 1);
        check("start lose", lose, 0);
    endtask

    task automatic enter(input logic [SW_W-1:0] value, input int exp_good);
        sw      = value;
        confirm = 1'b1;
        good_q.push_back(exp_good);
        @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        check("entry good", good, good_q.pop_front());
    endtask

    initial begin
        vecs[0] = '{2'd0, 2'd1, A_TIMEOUT, 32, 0,  1, 0, 1'b0, 1'b1};
        vecs[1] = '{2'd3, 2'd0, A_WRONG2,  20, 0,  1, 1, 1'b0, 1'b1};
        vecs[2] = '{2'd1, 2'd2, A_WIN,     28, 24, 2, 3, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 2'd2, A_LATE,    24, 0,  1, 1, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; confirm = 1'b0; sw = '0; difficulty = '0;
        mlfsr = SEED;
        repeat (3) @(negedge clk);
        check("rst led", led, 0);
        check("rst level", level, 0);
        check("rst good", good, 0);
        check("rst busy", busy, 0);
        check("rst input_en", input_en, 0);
        check("rst win", win, 0);
        check("rst lose", lose, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            start_game(vecs[v].diff, vecs[v].newdiff);
            run_show(2, vecs[v].show1, $sformatf("v%0d L1", v));
            case (vecs[v].act)
                A_TIMEOUT: begin
                    repeat (9) @(negedge clk);
                    check("timeout early", lose, 0);
                    @(negedge clk);
                    check("timeout edge", lose, 1);
                end
                A_WRONG2: begin
                    enter(cur[0], 1);
                    enter(~cur[1], 1);
                    check("wrong lose", lose, 1);
                    sw = cur[1]; confirm = 1'b1;
                    @(negedge clk);
                    confirm = 1'b0;
                    @(negedge clk);
                    check("ignored confirm good", good, 1);
                    check("ignored confirm input_en", input_en, 0);
                end
                A_WIN: begin
                    enter(cur[0], 1);
                    enter(cur[1], 2);
                    @(negedge clk);
                    check("pass level", level, 2);
                    run_show(3, vecs[v].show2, "L2");
                    enter(cur[0], 1);
                    enter(cur[1], 2);
                    enter(cur[2], 3);
                    @(negedge clk);
                end
                default: begin
                    repeat (9) @(negedge clk);
                    check("late early", lose, 0);
                    enter(cur[0], 1);
                    repeat (9) @(negedge clk);
                    check("late restart", lose, 0);
                    @(negedge clk);
                    check("late edge", lose, 1);
                end
            endcase
            check($sformatf("v%0d level", v), level, vecs[v].exp_level);
            check($sformatf("v%0d good", v), good, vecs[v].exp_good);
            check($sformatf("v%0d win", v), win, vecs[v].exp_win);
            check($sformatf("v%0d lose", v), lose, vecs[v].exp_lose);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of SHOW
        start_game(2'd0, 2'd0);
        repeat (5) @(negedge clk);
        check("pre-reset busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async led", led, 0);
        check("async level", level, 0);
        check("async busy", busy, 0);
        check("async win", win, 0);
        @(negedge clk);
        reset = 1'b0;
        mlfsr = SEED;
        pat_q.delete();
        @(negedge clk);
        check("idle busy", busy, 0);
        check("idle input_en", input_en, 0);
        start_game(2'd0, 2'd0);
        run_show(2, 32, "post-reset");
        repeat (10) @(negedge clk);
        check("post-reset timeout", lose, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
